video_timing_analyzer: RTL

VIDEO_TIMING_ANALYZER -- requirements
Module: video_timing_analyzer

---
 rtl/video_timing_analyzer_if.sv | 22 ++
 rtl/video_timing_analyzer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_analyzer_if.sv
// Video timing bus: raster inputs from the source, measurement results back.
// The slave modport is the analyzer side; the master modport is the source side.
`timescale 1ns/1ps
interface video_timing_analyzer_if;
  logic       PCE, HSYN, VSYN, HBLK, VBLK;
  logic [9:0] HPOS, VPOS, H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE;
  logic [7:0] HS_WIDTH;
  logic [3:0] VS_WIDTH;
  logic       LOCKED, FRAME, ERR;

  modport master (
    output PCE, HSYN, VSYN, HBLK, VBLK,
    input  HPOS, VPOS, H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE,
    input  HS_WIDTH, VS_WIDTH, LOCKED, FRAME, ERR
  );

  modport slave (
    input  PCE, HSYN, VSYN, HBLK, VBLK,
    output HPOS, VPOS, H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE,
    output HS_WIDTH, VS_WIDTH, LOCKED, FRAME, ERR
  );
endinterface

// File: rtl/video_timing_analyzer.sv
// Recovers raster position and measures line/frame geometry, locking after two equal frames.
// Define VTA_SYNC_WIDTH_EN to also measure sync pulse widths and include them in the lock check.
`timescale 1ns/1ps
module video_timing_analyzer (
  input  logic                   MCLK,
  input  logic                   RESET,
  video_timing_analyzer_if.slave vid
);
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCKED} state_e;

  localparam logic [9:0] MAX10 = 10'd1023;

  function automatic logic [9:0] inc10(input logic [9:0] v, input logic en);
    return (en && v != MAX10) ? v + 10'd1 : v;
  endfunction

  state_e     state_q, state_d;
  logic       hs_hist_q, vs_hist_q;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0] hact_q, hact_d, vact_q, vact_d;
  logic [9:0] lhtot_q, lhtot_d, lhact_q, lhact_d;
  logic [9:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic       frame_q, err_q;
  logic       hs_fall, vs_fall, line_to, frame_to, timeout, latch, match, base_match;
  logic [9:0] f_htot, f_hact, f_vtot, f_vact;

  assign hs_fall = vid.PCE & hs_hist_q & ~vid.HSYN;
  assign vs_fall = vid.PCE & vs_hist_q & ~vid.VSYN;
  assign timeout = line_to | frame_to;

  // Values of the frame closing on this PCE; a coincident HSYN fall closes its line first
  assign f_htot = hs_fall ? inc10(hpos_q, 1'b1) : lhtot_q;
  assign f_hact = hs_fall ? hact_q : lhact_q;
  assign f_vtot = inc10(vpos_q, hs_fall);
  assign f_vact = inc10(vact_q, hs_fall & ~vid.VBLK);

  always_comb begin
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hact_d   = hact_q;
    vact_d   = vact_q;
    lhtot_d  = lhtot_q;
    lhact_d  = lhact_q;
    line_to  = 1'b0;
    frame_to = 1'b0;
    if (vid.PCE) begin
      hpos_d = hs_fall ? 10'd0 : inc10(hpos_q, 1'b1);
      hact_d = hs_fall ? {9'd0, ~vid.HBLK} : inc10(hact_q, ~vid.HBLK);
      if (hs_fall) begin
        lhtot_d = f_htot;
        lhact_d = hact_q;
      end
      vpos_d   = vs_fall ? 10'd0 : f_vtot;
      vact_d   = vs_fall ? 10'd0 : f_vact;
      // hpos 1021 -> 1022 is the 1023rd PCE of the line
      line_to  = ~hs_fall && (hpos_q == 10'd1021);
      frame_to = hs_fall && ~vs_fall && (vpos_q == 10'd1022);
    end
  end

`ifdef VTA_SYNC_WIDTH_EN
  logic [7:0] hsw_q, hsw_d, lhsw_q, lhsw_d, hs_width_q, f_hsw;
  logic [3:0] vsw_q, vsw_d, vs_width_q, f_vsw;

  assign f_hsw = hs_fall ? hsw_q : lhsw_q;
  assign f_vsw = (hs_fall && ~vid.VSYN && vsw_q != 4'hf) ? vsw_q + 4'd1 : vsw_q;

  always_comb begin
    hsw_d  = hsw_q;
    lhsw_d = lhsw_q;
    vsw_d  = vsw_q;
    if (vid.PCE) begin
      if (hs_fall) begin
        hsw_d  = 8'd1;
        lhsw_d = hsw_q;
      end else if (~vid.HSYN && hsw_q != 8'hff) begin
        hsw_d = hsw_q + 8'd1;
      end
      vsw_d = vs_fall ? 4'd0 : f_vsw;
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      hsw_q      <= '0;
      lhsw_q     <= '0;
      vsw_q      <= '0;
      hs_width_q <= '0;
      vs_width_q <= '0;
    end else begin
      hsw_q  <= hsw_d;
      lhsw_q <= lhsw_d;
      vsw_q  <= vsw_d;
      if (latch) begin
        hs_width_q <= f_hsw;
        vs_width_q <= f_vsw;
      end
    end
  end

  assign match        = base_match && (f_hsw == hs_width_q) && (f_vsw == vs_width_q);
  assign vid.HS_WIDTH = hs_width_q;
  assign vid.VS_WIDTH = vs_width_q;
`else
  assign match        = base_match;
  assign vid.HS_WIDTH = 8'd0;
  assign vid.VS_WIDTH = 4'd0;
`endif

  assign base_match = (f_htot == h_total_q) && (f_hact == h_active_q) &&
                      (f_vtot == v_total_q) && (f_vact == v_active_q);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    if (timeout) begin
      state_d = ST_SEARCH;
    end else if (vs_fall) begin
      case (state_q)
        ST_SEARCH:  state_d = ST_MEASURE;
        ST_MEASURE: begin
          latch   = 1'b1;
          state_d = ST_VERIFY;
        end
        ST_VERIFY, ST_LOCKED: begin
          latch   = 1'b1;
          state_d = match ? ST_LOCKED : ST_VERIFY;
        end
        default:    state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_SEARCH;
      hs_hist_q  <= 1'b1;
      vs_hist_q  <= 1'b1;
      hpos_q     <= '0;
      vpos_q     <= '0;
      hact_q     <= '0;
      vact_q     <= '0;
      lhtot_q    <= '0;
      lhact_q    <= '0;
      h_total_q  <= '0;
      h_active_q <= '0;
      v_total_q  <= '0;
      v_active_q <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (vid.PCE) begin
        hs_hist_q <= vid.HSYN;
        vs_hist_q <= vid.VSYN;
      end
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hact_q  <= hact_d;
      vact_q  <= vact_d;
      lhtot_q <= lhtot_d;
      lhact_q <= lhact_d;
      frame_q <= latch;
      err_q   <= err_q | timeout;
      if (latch) begin
        h_total_q  <= f_htot;
        h_active_q <= f_hact;
        v_total_q  <= f_vtot;
        v_active_q <= f_vact;
      end
    end
  end

  assign vid.HPOS     = hpos_q;
  assign vid.VPOS     = vpos_q;
  assign vid.H_TOTAL  = h_total_q;
  assign vid.H_ACTIVE = h_active_q;
  assign vid.V_TOTAL  = v_total_q;
  assign vid.V_ACTIVE = v_active_q;
  assign vid.LOCKED   = (state_q == ST_LOCKED);
  assign vid.FRAME    = frame_q;
  assign vid.ERR      = err_q;
endmodule
